// File: rtl/pattern_player.sv
// Plays back a latched pattern, oldest bit first, as timed LED pulses
// separated by blank gaps; reports busy while playing and a done pulse at the end.
//
// state | meaning
// IDLE  | waiting for start; done pulses here for one cycle after playback
// SHOW  | presenting latched_pattern[index] with led_valid high for ON_CYCLES
// GAP   | blank gap of OFF_CYCLES after each bit
module pattern_player #(
  parameter int unsigned ON_CYCLES  = 4,
  parameter int unsigned OFF_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] pattern,
  input  logic [15:0] length,
  output logic        led_valid,
  output logic        led_bit,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [15:0] ON_LOAD  = 16'(ON_CYCLES - 1);
  localparam logic [15:0] OFF_LOAD = 16'(OFF_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] timer, timer_nxt;
  logic [4:0]  index, index_nxt;
  logic [31:0] pat_q, pat_nxt;
  logic [5:0]  eff_len;
  logic        done_nxt;
  logic        led_valid_nxt;
  logic        led_bit_nxt;
  logic        busy_nxt;

  assign eff_len = (length > 16'd32) ? 6'd32 : length[5:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      index     <= '0;
      pat_q     <= '0;
      led_valid <= 1'b0;
      led_bit   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      index     <= index_nxt;
      pat_q     <= pat_nxt;
      led_valid <= led_valid_nxt;
      led_bit   <= led_bit_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    index_nxt = index;
    pat_nxt   = pat_q;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          pat_nxt = pattern;
          if (eff_len == 6'd0) begin
            done_nxt = 1'b1;
          end else begin
            index_nxt = 5'(eff_len - 6'd1);
            state_nxt = SHOW;
            timer_nxt = ON_LOAD;
          end
        end
      end
      SHOW: begin
        if (abort) begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end else if (timer == 16'd0) begin
          state_nxt = GAP;
          timer_nxt = OFF_LOAD;
        end else begin
          timer_nxt = timer - 16'd1;
        end
      end
      GAP: begin
        if (abort) begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end else if (timer == 16'd0) begin
          if (index == 5'd0) begin
            state_nxt = IDLE;
            timer_nxt = '0;
            done_nxt  = 1'b1;
          end else begin
            index_nxt = index - 5'd1;
            state_nxt = SHOW;
            timer_nxt = ON_LOAD;
          end
        end else begin
          timer_nxt = timer - 16'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  // Outputs are derived from the next state so they register in step with it.
  always_comb begin
    led_valid_nxt = (state_nxt == SHOW);
    led_bit_nxt   = led_valid_nxt & pat_nxt[index_nxt];
    busy_nxt      = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_pattern_player.sv
// Directed self-checking bench for pattern_player with ON_CYCLES=4, OFF_CYCLES=2.
module tb_pattern_player;

  localparam int ON  = 4;
  localparam int OFF = 2;
  localparam int PER = ON + OFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] pattern;
  logic [15:0] length;
  logic        led_valid;
  logic        led_bit;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  pattern_player #(.ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .pattern   (pattern),
    .length    (length),
    .led_valid (led_valid),
    .led_bit   (led_bit),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Expected {led_valid, led_bit, busy, done} at cycle c after a start at cycle 0.
  function automatic logic [3:0] expect_at(input logic [31:0] pat, input int n, input int c);
    int  slot;
    int  pos;
    logic v;
    logic b;
    if (c >= 1 && c <= n * PER) begin
      slot = (c - 1) / PER;
      pos  = (c - 1) % PER;
      v    = (pos < ON);
      b    = v & pat[n - 1 - slot];
      return {v, b, 1'b1, 1'b0};
    end
    if (c == n * PER + 1) return 4'b0001;
    return 4'b0000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [31:0] pat, input logic [15:0] len);
    pattern = pat;
    length  = len;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; abort = 1'b1; pattern = 32'hFFFF_FFFF; length = 16'd3;
    step(); step(); step();
    n_cmp++;
    if ({led_valid, led_bit, busy, done} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_outputs got %b want 0000", {led_valid, led_bit, busy, done});
    end
    start = 1'b0; abort = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [3:0] e;
    kick(32'h5, 16'd3);
    for (int c = 1; c <= 22; c++) begin
      e = expect_at(32'h5, 3, c);
      n_cmp++;
      if ({led_valid, led_bit, busy, done} !== e) begin
        n_bad++;
        $display("FAIL basic c=%0d got %b want %b", c, {led_valid, led_bit, busy, done}, e);
      end
      step();
    end
  endtask

  task automatic test_zero_len();
    kick(32'hFFFF_FFFF, 16'd0);
    for (int c = 1; c <= 4; c++) begin
      n_cmp++;
      if ({led_valid, led_bit, busy, done} !== ((c == 1) ? 4'b0001 : 4'b0000)) begin
        n_bad++;
        $display("FAIL zero_len c=%0d got %b want %b", c, {led_valid, led_bit, busy, done},
                 (c == 1) ? 4'b0001 : 4'b0000);
      end
      step();
    end
  endtask

  task automatic test_long();
    int on_cnt   = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int bits     = 0;
    logic prev_v = 1'b0;
    kick(32'hFFFF_FFFF, 16'd40);
    for (int c = 1; c <= 200; c++) begin
      if (led_valid) on_cnt++;
      if (led_valid && !prev_v) bits++;
      prev_v = led_valid;
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      step();
    end
    n_cmp++;
    if (bits !== 32) begin
      n_bad++; $display("FAIL long_bits got %0d want 32", bits);
    end
    n_cmp++;
    if (on_cnt !== 32 * ON) begin
      n_bad++; $display("FAIL long_on_cycles got %0d want %0d", on_cnt, 32 * ON);
    end
    n_cmp++;
    if (done_cyc !== 193 || done_cnt !== 1) begin
      n_bad++; $display("FAIL long_done got cycle %0d count %0d want cycle 193 count 1", done_cyc, done_cnt);
    end
  endtask

  task automatic test_abort();
    logic [3:0] e;
    kick(32'h5, 16'd3);
    for (int c = 1; c <= 25; c++) begin
      e = (c <= 7) ? expect_at(32'h5, 3, c) : 4'b0000;
      n_cmp++;
      if ({led_valid, led_bit, busy, done} !== e) begin
        n_bad++;
        $display("FAIL abort c=%0d got %b want %b", c, {led_valid, led_bit, busy, done}, e);
      end
      abort = (c == 7);
      step();
    end
    abort = 1'b0;
    // abort together with start in IDLE must not start playback
    abort = 1'b1;
    kick(32'h1, 16'd1);
    abort = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      n_cmp++;
      if ({led_valid, led_bit, busy, done} !== 4'b0000) begin
        n_bad++;
        $display("FAIL abort_start c=%0d got %b want 0000", c, {led_valid, led_bit, busy, done});
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] e;
    kick(32'h6, 16'd3);
    for (int c = 1; c <= 26 + 3; c++) begin
      if (c <= 19) e = expect_at(32'h6, 3, c);
      else         e = expect_at(32'h1, 1, c - 19);
      n_cmp++;
      if ({led_valid, led_bit, busy, done} !== e) begin
        n_bad++;
        $display("FAIL back_to_back c=%0d got %b want %b", c, {led_valid, led_bit, busy, done}, e);
      end
      start = 1'b0;
      if (c == 3) begin
        start = 1'b1; pattern = 32'h0; length = 16'd5;
      end
      if (c == 5) pattern = 32'hFFFF_FFFF;
      if (c == 19) begin
        start = 1'b1; pattern = 32'h1; length = 16'd1;
      end
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_mid_reset();
    kick(32'h5, 16'd3);
    for (int c = 1; c <= 5; c++) begin
      n_cmp++;
      if ({led_valid, led_bit, busy, done} !== expect_at(32'h5, 3, c)) begin
        n_bad++;
        $display("FAIL mid_reset_pre c=%0d got %b want %b", c, {led_valid, led_bit, busy, done},
                 expect_at(32'h5, 3, c));
      end
      if (c < 5) step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++;
    if ({led_valid, led_bit, busy, done} !== 4'b0000) begin
      n_bad++;
      $display("FAIL mid_reset_after got %b want 0000", {led_valid, led_bit, busy, done});
    end
    kick(32'h1, 16'd1);
    for (int c = 1; c <= 10; c++) begin
      n_cmp++;
      if ({led_valid, led_bit, busy, done} !== expect_at(32'h1, 1, c)) begin
        n_bad++;
        $display("FAIL mid_reset_restart c=%0d got %b want %b", c, {led_valid, led_bit, busy, done},
                 expect_at(32'h1, 1, c));
      end
      step();
    end
  endtask

  initial begin
    start = 1'b0; abort = 1'b0; pattern = '0; length = '0; rst_n = 1'b0;
    #2;
    test_reset();
    test_basic();
    test_zero_len();
    test_long();
    test_abort();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
